// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC array control slice.
// Holds the drain FSM states and the element selector for the packed result matrix.
package mac_pkg;

  localparam int MAC_N      = 4;
  localparam int MAC_ELEM_W = 32;
  localparam int MAC_BUF_W  = MAC_N * MAC_N * MAC_ELEM_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    RELEASE = 2'd2
  } drain_state_t;

  // C[0][0] sits in the MSBs; elements follow in row-major order.
  function automatic logic [MAC_ELEM_W-1:0] elem_sel(
    input logic [MAC_BUF_W-1:0] buf_v,
    input int unsigned          r,
    input int unsigned          c
  );
    int unsigned k;
    k = r * MAC_N + c;
    return buf_v[MAC_BUF_W-1-MAC_ELEM_W*k -: MAC_ELEM_W];
  endfunction

endpackage

// File: rtl/mac_result_drain.sv
// Captures the systolic array's result matrix on the rising edge of its done level
// and streams the elements over valid/ready, then pulses release_pulse.
module mac_result_drain
  import mac_pkg::*;
#(
  parameter int N      = MAC_N,
  parameter int ELEM_W = MAC_ELEM_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  done_matrix_mult,
  input  logic [N*N*ELEM_W-1:0] y,
  input  logic                  col_major,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ELEM_W-1:0]     out_data,
  output logic [$clog2(N)-1:0]  out_row,
  output logic [$clog2(N)-1:0]  out_col,
  output logic                  out_last,
  output logic                  busy,
  // "release" is a reserved word in SystemVerilog, hence the suffix.
  output logic                  release_pulse,
  output logic                  overrun
);

  localparam int IW = $clog2(N * N);
  localparam int RW = $clog2(N);
  localparam int BW = N * N * ELEM_W;

  drain_state_t    state_q, state_d;
  logic            done_q, done_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [BW-1:0]   buf_q, buf_d;
  logic            order_q, order_d;
  logic            overrun_q, overrun_d;

  logic            start;
  logic [RW-1:0]   r_sel, c_sel;
  logic            last_sel;

  assign start = done_matrix_mult & ~done_q;

  // Index decode; N is a power of two, so the index splits into major/minor fields.
  always_comb begin
    r_sel = idx_q[IW-1 -: RW];
    c_sel = idx_q[RW-1:0];
    if (order_q) begin
      c_sel = idx_q[IW-1 -: RW];
      r_sel = idx_q[RW-1:0];
    end
    last_sel = (idx_q == IW'(N * N - 1));
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    done_d    = done_matrix_mult;
    idx_d     = idx_q;
    buf_d     = buf_q;
    order_d   = order_q;
    overrun_d = overrun_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          buf_d   = y;
          order_d = col_major;
          idx_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (last_sel) state_d = RELEASE;
          else          idx_d   = idx_q + IW'(1);
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A fresh done edge while a drain is in flight is dropped but remembered.
    if (start && (state_q != IDLE)) overrun_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: the capture buffer is reset too; the idle outputs must read as zero and
  // the register is small enough that a reset costs nothing meaningful.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      idx_q     <= '0;
      buf_q     <= '0;
      order_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      order_q   <= order_d;
      overrun_q <= overrun_d;
    end
  end

  // Outputs decode registered state only; out_ready never reaches the data path.
  always_comb begin
    out_valid     = (state_q == DRAIN);
    busy          = (state_q != IDLE);
    release_pulse = (state_q == RELEASE);
    overrun       = overrun_q;
    out_data      = '0;
    out_row       = '0;
    out_col       = '0;
    out_last      = 1'b0;
    if (state_q == DRAIN) begin
      out_data = elem_sel(buf_q, 32'(r_sel), 32'(c_sel));
      out_row  = r_sel;
      out_col  = c_sel;
      out_last = last_sel;
    end
  end

endmodule

// File: tb/tb_mac_result_drain.sv
// Directed bench for mac_result_drain: row/column-major drains, backpressure,
// overrun and reset in the middle of a drain.
module tb_mac_result_drain;
  import mac_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         done_matrix_mult;
  logic [511:0] y;
  logic         col_major;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic [1:0]   out_row;
  logic [1:0]   out_col;
  logic         out_last;
  logic         busy;
  logic         release_pulse;
  logic         overrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        cm;
    logic [31:0] exp_data;
    logic [1:0]  exp_row;
    logic [1:0]  exp_col;
    logic        exp_last;
  } vec_t;

  vec_t tbl[32];

  mac_result_drain dut (
    .clk             (clk),
    .reset           (reset),
    .done_matrix_mult(done_matrix_mult),
    .y               (y),
    .col_major       (col_major),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_row         (out_row),
    .out_col         (out_col),
    .out_last        (out_last),
    .busy            (busy),
    .release_pulse   (release_pulse),
    .overrun         (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise done; the following edge captures, leaving the DUT in its first drain cycle.
  task automatic trigger();
    done_matrix_mult = 1'b1;
    step();
  endtask

  // Drains 16 beats, comparing each accepted beat against tbl[base+beat].
  // ready_mode 1 accepts only on every third cycle (1,0,0,...).
  task automatic run_drain(input int base, input int ready_mode, input bit flip_cm,
                           input bit pulse_done, output int cycles);
    int beat;
    bit holding, dropped, raised;
    logic [31:0] held_data;
    logic [1:0]  held_row, held_col;
    beat = 0; cycles = 0; holding = 0; dropped = 0; raised = 0;
    held_data = '0; held_row = '0; held_col = '0;
    while (beat < 16 && cycles < 200) begin
      out_ready = (ready_mode == 0) ? 1'b1 : ((cycles % 3) == 0);
      if (holding) begin
        check("stall_data", out_data, held_data);
        check("stall_rowcol", {out_row, out_col}, {held_row, held_col});
      end
      check("valid", out_valid, 1'b1);
      check("data", out_data, tbl[base+beat].exp_data);
      check("row", out_row, tbl[base+beat].exp_row);
      check("col", out_col, tbl[base+beat].exp_col);
      check("last", out_last, tbl[base+beat].exp_last);
      check("no_release_in_drain", release_pulse, 1'b0);
      if (out_ready) begin
        beat++;
        holding = 0;
      end else begin
        holding   = 1;
        held_data = out_data;
        held_row  = out_row;
        held_col  = out_col;
      end
      if (flip_cm && beat == 3) col_major = ~tbl[base].cm;
      if (pulse_done && beat == 5 && !dropped) begin
        done_matrix_mult = 1'b0;
        dropped = 1;
      end else if (dropped && !raised) begin
        done_matrix_mult = 1'b1;
        raised = 1;
      end
      step();
      cycles++;
    end
    if (cycles >= 200) check("drain_timeout", cycles, 0);
  endtask

  // Release cycle, then back to IDLE; done is lowered so the next trigger is a real edge.
  task automatic after_drain();
    check("release_high", release_pulse, 1'b1);
    check("release_busy", busy, 1'b1);
    check("release_valid", out_valid, 1'b0);
    step();
    check("release_one_cycle", release_pulse, 1'b0);
    check("idle_busy", busy, 1'b0);
    done_matrix_mult = 1'b0;
    step();
  endtask

  initial begin
    int cyc;
    for (int b = 0; b < 16; b++) begin
      tbl[b].cm       = 1'b0;
      tbl[b].exp_row  = 2'(b / 4);
      tbl[b].exp_col  = 2'(b % 4);
      tbl[b].exp_data = 32'h1000_0000 + 32'(b);
      tbl[b].exp_last = (b == 15);
      tbl[16+b].cm       = 1'b1;
      tbl[16+b].exp_col  = 2'(b / 4);
      tbl[16+b].exp_row  = 2'(b % 4);
      tbl[16+b].exp_data = 32'h1000_0000 + 32'((b % 4) * 4 + (b / 4));
      tbl[16+b].exp_last = (b == 15);
    end
    for (int k = 0; k < 16; k++) y[511-32*k -: 32] = 32'h1000_0000 + 32'(k);

    reset = 1'b1; done_matrix_mult = 1'b0; out_ready = 1'b0; col_major = 1'b0;
    step(); step();
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 32'h0);
    check("rst_rowcol", {out_row, out_col}, 4'h0);
    check("rst_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_release", release_pulse, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    reset = 1'b0;
    step();

    // Row-major drain with done held high afterwards.
    trigger();
    run_drain(0, 0, 0, 0, cyc);
    check("rowmajor_cycles", cyc, 16);
    check("release_high", release_pulse, 1'b1);
    step();
    check("release_one_cycle", release_pulse, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("no_retrigger_valid", out_valid, 1'b0);
    end
    done_matrix_mult = 1'b0;
    step();

    // Backpressure: 16 beats at cycles 0,3,...,45.
    trigger();
    run_drain(0, 1, 0, 0, cyc);
    check("backpressure_cycles", cyc, 46);
    after_drain();

    // Column-major, order flipped mid-drain with no effect.
    col_major = 1'b1;
    trigger();
    run_drain(16, 0, 1, 0, cyc);
    check("colmajor_cycles", cyc, 16);
    after_drain();

    // Overrun at beat 5.
    col_major = 1'b0;
    check("overrun_before", overrun, 1'b0);
    trigger();
    run_drain(0, 0, 0, 1, cyc);
    check("overrun_set", overrun, 1'b1);
    after_drain();
    check("overrun_sticky", overrun, 1'b1);

    // Reset at beat 7, then restart with done already high.
    trigger();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("pre_reset_row", out_row, 2'd1);
    check("pre_reset_col", out_col, 2'd3);
    reset = 1'b1;
    #1;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_data", out_data, 32'h0);
    check("midrst_rowcol", {out_row, out_col}, 4'h0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_release", release_pulse, 1'b0);
    check("midrst_overrun", overrun, 1'b0);
    step();
    check("inrst_release", release_pulse, 1'b0);
    reset = 1'b0;
    step();
    run_drain(0, 0, 0, 0, cyc);
    check("restart_cycles", cyc, 16);
    after_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected $finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mac_result_drain.md
# mac_result_drain

Downstream drain stage for the 4x4 systolic MAC array. When the array raises its done level, the block captures the packed 512-bit result matrix. It then streams the 16 32-bit elements one per handshake over a valid/ready interface, tagged with row/column indices and a last flag. After the final element is accepted, it pulses `release` so control can restart the array.

## Interface
- `N`, 4, matrix dimension (N×N results)
- `ELEM_W`, 32, result element width in bits
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `done_matrix_mult`  in  1  level from the array; high while results are valid
- `y`  in  N*N*ELEM_W  packed results; C[0][0] in the MSBs, row-major, so element k = y[N*N*ELEM_W-1-ELEM_W*k -: ELEM_W]
- `col_major`  in  1  drain order select, sampled at capture
- `out_valid`  out  1  element available
- `out_ready`  in  1  consumer accepts
- `out_data`  out  ELEM_W  element value
- `out_row`  out  $clog2(N)  row index of `out_data`
- `out_col`  out  $clog2(N)  column index of `out_data`
- `out_last`  out  1  high with the final (16th) element
- `busy`  out  1  high in DRAIN and RELEASE
- `release`  out  1  one-cycle pulse after the last handshake
- `overrun`  out  1  sticky; a new done edge arrived while busy

## Operation
- Reset values:
  - outputs: `out_valid`=0, `out_data`=0, `out_row`=0, `out_col`=0, `out_last`=0, `busy`=0, `release`=0, `overrun`=0
  - internal: state=IDLE, `done_q`=0, `idx`=0, capture buffer=0, `order_q`=0
- Trigger:
  - `done_q` registers `done_matrix_mult` every cycle.
  - `start` = `done_matrix_mult` & ~`done_q`.
  - A level held high never retriggers.
- States:
  - IDLE:
    - On `start`, capture `y` into the buffer, latch `col_major` into `order_q`, set `idx`=0, go to DRAIN.
    - Otherwise stay in IDLE.
  - DRAIN:
    - `out_valid`=1.
    - Element position: row-major gives r=`idx`/N, c=`idx`%N; col-major gives c=`idx`/N, r=`idx`%N.
    - `out_data`=buffer[r][c], `out_row`=r, `out_col`=c, `out_last`=(`idx`==N*N-1).
    - On handshake (`out_valid` & `out_ready`): if `out_last`, go to RELEASE; else `idx`++.
  - RELEASE: `release`=1 for one cycle, then return to IDLE.
- Output stability:
  - While `out_valid` & ~`out_ready`, `out_data`, `out_row`, `out_col` and `out_last` hold stable.
  - The buffer is never rewritten outside IDLE.
- Overrun:
  - `start` in DRAIN or RELEASE sets `overrun`.
  - The edge is dropped; the buffer and `idx` are unaffected.
  - `overrun` clears only on reset.
- Width rules:
  - `idx` is $clog2(N*N) bits and does not wrap; the exit from DRAIN is at `out_last`.
  - Data passes through unmodified; no sign handling.
- Reset mid-drain: all state returns to reset values immediately (asynchronous). No partial `release` is issued.

## Timing
- Capture happens at edge T, where `done_matrix_mult`=1 and `done_q`=0 in the cycle before T.
- `out_valid` is first high in cycle T+1; with `out_ready` held high, the elements occupy cycles T+1..T+16.
- `release` is high in cycle T+17; IDLE is re-entered at T+18.
- A new `start` is accepted from T+18 onward.
- Throughput is one element per cycle. Backpressure adds exactly one cycle per stalled cycle.
- All outputs are registered or decoded from registered state; there is no combinational path from `out_ready` to `out_data`.
- `out_valid` may depend combinationally on state only.

## Structure
- Shared package `mac_pkg`:
  - `drain_state_t` enum: IDLE, DRAIN, RELEASE.
  - Constants `MAC_N`=4 and `MAC_ELEM_W`=32, used as the parameter defaults.
  - Function `elem_sel(buf, r, c)` returning the ELEM_W slice.
- No sub-module is needed; the block is a single module with one FSM, an index counter and a capture register.

## Test plan
- Basic row-major drain:
  - Stimulus: `y` element k = 32'h1000_0000+k, `done_matrix_mult` raised and held, `out_ready`=1.
  - Required: 16 consecutive beats of 1000_0000..1000_000F; (row, col) goes (0,0)…(3,3); `out_last` only on beat 16; `release` one cycle later; no second drain while done stays high.
- Backpressure:
  - Stimulus: same `y`; `out_ready` toggles 1,0,0,1… .
  - Required: no beats lost or duplicated; `out_data` stable during stalls; total drain cycles = 16 + stall cycles.
- Column-major:
  - Stimulus: `col_major`=1 at capture, then changed to 0 mid-drain.
  - Required: order is k=0,4,8,12,1,5,…,15; `out_row`/`out_col` match; the mid-drain change has no effect.
- Overrun:
  - Stimulus: drop and re-raise `done_matrix_mult` at beat 5.
  - Required: `overrun`=1 and stays 1; the remaining beats still come from the original capture.
- Reset mid-drain:
  - Stimulus: assert `reset` at beat 7.
  - Required: all outputs 0 within the same cycle; after reset deasserts with done already high, a fresh done edge restarts the drain from (0,0).
